// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 issue datapath: op codes, flag bit positions and FSM states.
package alu32_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic {StIdle, StExec} state_e;

  function automatic logic is_arith(logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU with {c,n,z,v} flags; c on sub means "no borrow".
module alu32
  import alu32_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);

  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        c, v;

  always_comb begin
    b_eff    = (op_i == OP_SUB) ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, (op_i == OP_SUB)};
    result_o = '0;
    c        = 1'b0;
    v        = 1'b0;
    unique case (op_i)
      OP_NOTA: result_o = ~a_i;
      OP_NOTB: result_o = ~b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_ADD, OP_SUB: begin
        result_o = sum[31:0];
        c        = sum[32];
        v        = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
      end
      default: result_o = '0;
    endcase
    flags_o        = '0;
    flags_o[FLG_C] = c;
    flags_o[FLG_N] = result_o[31];
    flags_o[FLG_Z] = (result_o == 32'd0);
    flags_o[FLG_V] = v;
  end

endmodule

// File: rtl/alu32_rsp_fifo.sv
// Power-of-two response FIFO; pointers wrap naturally at Depth.
module alu32_rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 40
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/alu32_seq.sv
// Issues ALU commands to an external alu32 and returns results in order through a FIFO.
// Optional sticky carry/overflow tracking is enabled with ALU_STICKY_FLAGS_EN.
module alu32_seq
  import alu32_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [31:0]      cmd_a_i,
  input  logic [31:0]      cmd_b_i,
  input  logic             cmd_acc_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [2:0]       alu_op_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  input  logic [31:0]      alu_result_i,
  input  logic [3:0]       alu_flags_i,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic             clr_sticky_i,
  output logic [1:0]       sticky_cv_o,
`endif
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic [TAG_W-1:0] rsp_tag_o
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned RspW  = 32 + 4 + TAG_W;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d, acc_q;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CntW-1:0]   count;
  logic [CntW:0]     occupancy;
  logic              accept, push, pop, full, empty;
  logic [RspW-1:0]   rsp_data;

  // An in-flight EXEC command already owns a FIFO slot.
  assign occupancy   = {1'b0, count} + {{CntW{1'b0}}, (state_q == StExec)};
  assign cmd_ready_o = reset_ni && (state_q == StIdle) && (occupancy < (CntW + 1)'(DEPTH));
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign push        = (state_q == StExec);
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
          op_d    = cmd_op_i;
          a_d     = cmd_acc_i ? acc_q : cmd_a_i;
          b_d     = cmd_b_i;
          tag_d   = cmd_tag_i;
        end
      end
      StExec:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      if (push) acc_q <= alu_result_i;
    end
  end

  assign alu_op_o = op_q;
  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;

  alu32_rsp_fifo #(
    .Depth (DEPTH),
    .Width (RspW)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .push_i  (push),
    .data_i  ({alu_result_i, alu_flags_i, tag_q}),
    .pop_i   (pop),
    .data_o  (rsp_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign rsp_valid_o  = !empty;
  assign rsp_result_o = rsp_data[RspW-1 -: 32];
  assign rsp_flags_o  = rsp_data[TAG_W +: 4];
  assign rsp_tag_o    = rsp_data[TAG_W-1:0];

  a_ready_not_full: assert property (@(posedge clk_i) disable iff (!reset_ni)
                                     cmd_ready_o |-> !full);

`ifdef ALU_STICKY_FLAGS_EN
  logic [1:0] sticky_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sticky_q <= '0;
    end else if (clr_sticky_i) begin
      sticky_q <= '0;
    end else if (push && is_arith(op_q)) begin
      sticky_q <= sticky_q | {alu_flags_i[FLG_C], alu_flags_i[FLG_V]};
    end
  end

  assign sticky_cv_o = sticky_q;
`endif

endmodule

// File: tb/tb_alu32_seq.sv
// Scoreboard bench for alu32_seq wired to alu32; directed vectors with hand-computed results.
module tb_alu32_seq;
  import alu32_pkg::*;

  logic        clk, reset_n;
  logic        cmd_valid, cmd_ready, cmd_acc;
  logic [2:0]  cmd_op, alu_op;
  logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  cmd_tag, alu_flags, rsp_flags, rsp_tag;
  logic        rsp_valid, rsp_ready;
`ifdef ALU_STICKY_FLAGS_EN
  logic        clr_sticky;
  logic [1:0]  sticky_cv;
`endif

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  alu32_seq #(.DEPTH(2), .TAG_W(4)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_acc_i    (cmd_acc),
    .cmd_tag_i    (cmd_tag),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_result),
    .alu_flags_i  (alu_flags),
`ifdef ALU_STICKY_FLAGS_EN
    .clr_sticky_i (clr_sticky),
    .sticky_cv_o  (sticky_cv),
`endif
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_flags_o  (rsp_flags),
    .rsp_tag_o    (rsp_tag)
  );

  alu32 u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshaken response must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got tag %0d result %h with nothing expected",
                 rsp_tag, rsp_result);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check($sformatf("rsp_tag%0d", e.t), {24'd0, rsp_result, rsp_flags, rsp_tag}, {24'd0, e});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic acc, input logic [3:0] tag, input logic [31:0] er,
                       input logic [3:0] ef, input bit expect_rsp);
    bit done = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc; cmd_tag = tag;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        if (expect_rsp) exp_q.push_back('{r: er, f: ef, t: tag});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!done) check($sformatf("accept_tag%0d", tag), 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int rdy_cnt;
    int bad_hold;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_acc = 1'b0; cmd_tag = '0; rsp_ready = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
    clr_sticky = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_opab", {alu_op, alu_a, alu_b}, 0);
    check("rst_rsp_data", {rsp_result, rsp_flags, rsp_tag}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", cmd_ready, 1);

    // add 5+7 and latency: EXEC cycle, then response visible
    issue(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd1, 32'd12, 4'b0000, 1);
    @(negedge clk);
    check("exec_alu_drive", {alu_op, alu_a, alu_b}, {3'(OP_ADD), 32'd5, 32'd7});
    check("lat_exec_no_valid", rsp_valid, 0);
    @(negedge clk);
    check("lat_valid", rsp_valid, 1);
    @(posedge clk); #1;

    // sub to zero, then accumulator sub
    issue(OP_SUB, 32'd3, 32'd3, 1'b0, 4'd2, 32'd0, 4'b1010, 1);
    issue(OP_SUB, 32'hDEAD_BEEF, 32'd1, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'b0100, 1);
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd4, 32'h8000_0000, 4'b0101, 1);
    issue(OP_NOTA, 32'd0, 32'd123, 1'b0, 4'd5, 32'hFFFF_FFFF, 4'b0100, 1);
    issue(OP_XOR, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 4'd6, 32'h0000_0FF0, 4'b0000, 1);
    issue(OP_NOTB, 32'd9, 32'hFFFF_FFFF, 1'b0, 4'd7, 32'd0, 4'b0010, 1);
    drain();

    // back-pressure: only DEPTH accepted, head stays put
    rsp_ready = 1'b0;
    issue(OP_OR, 32'd1, 32'd2, 1'b0, 4'd7, 32'd3, 4'b0000, 1);
    issue(OP_XNOR, 32'd0, 32'd0, 1'b0, 4'd8, 32'hFFFF_FFFF, 4'b0100, 1);
    cmd_op = OP_AND; cmd_a = 32'hF; cmd_b = 32'h3; cmd_acc = 1'b0; cmd_tag = 4'd9;
    cmd_valid = 1'b1;
    rdy_cnt = 0;
    bad_hold = 0;
    repeat (8) begin
      @(negedge clk);
      if (cmd_ready) rdy_cnt++;
      if (!rsp_valid || rsp_tag != 4'd7 || rsp_result != 32'd3) bad_hold++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("full_ready_low", rdy_cnt, 0);
    check("full_head_stable", bad_hold, 0);
    rsp_ready = 1'b1;
    issue(OP_AND, 32'hF, 32'h3, 1'b0, 4'd9, 32'd3, 4'b0000, 1);
    issue(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd10, 32'd2, 4'b0000, 1);
    drain();

    // reset during EXEC drops the command and clears the accumulator
    issue(OP_ADD, 32'd100, 32'd200, 1'b0, 4'd11, 32'd300, 4'b0000, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_ready", cmd_ready, 0);
    check("midrst_alu_a", alu_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    issue(OP_ADD, 32'd555, 32'd9, 1'b1, 4'd12, 32'd9, 4'b0000, 1);
    drain();

`ifdef ALU_STICKY_FLAGS_EN
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_cleared0", sticky_cv, 2'b00);
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'd13, 32'h8000_0000, 4'b0101, 1);
    issue(OP_AND, 32'hF, 32'h3, 1'b0, 4'd14, 32'd3, 4'b0000, 1);
    @(posedge clk); #1;
    check("sticky_v", sticky_cv, 2'b01);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_clr", sticky_cv, 2'b00);
    drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_rsp_valid", rsp_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
